// File: rtl/branch_feedback_queue.sv
// In-order queue of fetch-time branch predictions; drives predictor feedback when EX resolves the oldest.
// Optional statistics counters are built when BFQ_STATS_EN is defined.
module branch_feedback_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pred_valid,
  input  logic [ADDR_W-1:0]          i_pred_pc,
  input  logic                       i_pred_taken,
  output logic                       o_pred_ready,
  input  logic                       i_res_valid,
  input  logic                       i_res_taken,
  output logic                       o_res_ready,
  input  logic                       i_flush,
  output logic                       o_fb_valid,
  output logic [ADDR_W-1:0]          o_fb_pc,
  output logic                       o_fb_prediction,
  output logic                       o_fb_outcome,
  output logic                       o_mispredict,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_err,
  output logic [31:0]                o_stat_total,
  output logic [31:0]                o_stat_miss
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [ADDR_W-1:0] mem_pc_r [DEPTH];
  logic [DEPTH-1:0]  mem_taken_r;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              err_r;
  logic              fb_valid_r, fb_pred_r, fb_out_r, mispredict_r;
  logic [ADDR_W-1:0] fb_pc_r;

  logic              pred_ready_s, res_ready_s, push_s, res_s, err_set_s, mis_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic              head_taken_s;
  logic [PW-1:0]     rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CW-1:0]     count_nxt_s;

  // Handshake decode and next pointer/count; a full queue still accepts a push when the head retires.
  always_comb begin
    pred_ready_s = (count_r != FULL_C);
    res_ready_s  = (count_r != {CW{1'b0}});
    res_s        = i_res_valid & res_ready_s;
    push_s       = i_pred_valid & ~i_flush & (pred_ready_s | res_s);
    err_set_s    = (i_pred_valid & ~i_flush & ~push_s) | (i_res_valid & ~res_ready_s);
    head_pc_s    = mem_pc_r[rd_ptr_r];
    head_taken_s = mem_taken_r[rd_ptr_r];
    mis_s        = res_s & (head_taken_s != i_res_taken);
    rd_ptr_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, res_s};
    if (i_flush) begin
      // the resolving branch (if any) is kept; everything younger is squashed
      wr_ptr_nxt_s = rd_ptr_nxt_s;
      count_nxt_s  = {CW{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
      count_nxt_s  = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, res_s};
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc_r[wr_ptr_r]    <= i_pred_pc;
      mem_taken_r[wr_ptr_r] <= i_pred_taken;
    end
  end

  // Pointers, occupancy and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      err_r    <= err_r | err_set_s;
    end
  end

  // Feedback bus: strobes pulse for one cycle, payload holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid_r   <= 1'b0;
      mispredict_r <= 1'b0;
      fb_pc_r      <= {ADDR_W{1'b0}};
      fb_pred_r    <= 1'b0;
      fb_out_r     <= 1'b0;
    end else begin
      fb_valid_r   <= res_s;
      mispredict_r <= mis_s;
      if (res_s) begin
        fb_pc_r   <= head_pc_s;
        fb_pred_r <= head_taken_s;
        fb_out_r  <= i_res_taken;
      end else begin
        fb_pc_r   <= fb_pc_r;
        fb_pred_r <= fb_pred_r;
        fb_out_r  <= fb_out_r;
      end
    end
  end

`ifdef BFQ_STATS_EN
  logic [31:0] stat_total_r, stat_miss_r;

  // Saturating counters, updated on the same edge that raises o_fb_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total_r <= 32'd0;
      stat_miss_r  <= 32'd0;
    end else begin
      if (res_s && (stat_total_r != 32'hFFFF_FFFF)) begin
        stat_total_r <= stat_total_r + 32'd1;
      end else begin
        stat_total_r <= stat_total_r;
      end
      if (mis_s && (stat_miss_r != 32'hFFFF_FFFF)) begin
        stat_miss_r <= stat_miss_r + 32'd1;
      end else begin
        stat_miss_r <= stat_miss_r;
      end
    end
  end

  assign o_stat_total = stat_total_r;
  assign o_stat_miss  = stat_miss_r;
`else
  assign o_stat_total = 32'd0;
  assign o_stat_miss  = 32'd0;
`endif

  assign o_pred_ready    = pred_ready_s;
  assign o_res_ready     = res_ready_s;
  assign o_count         = count_r;
  assign o_err           = err_r;
  assign o_fb_valid      = fb_valid_r;
  assign o_mispredict    = mispredict_r;
  assign o_fb_pc         = fb_pc_r;
  assign o_fb_prediction = fb_pred_r;
  assign o_fb_outcome    = fb_out_r;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Randomised + directed bench for branch_feedback_queue against a queue-based reference model.
module tb_branch_feedback_queue;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pred_valid, i_pred_taken, i_res_valid, i_res_taken, i_flush;
  logic [ADDR_W-1:0] i_pred_pc;
  logic              o_pred_ready, o_res_ready, o_fb_valid, o_fb_prediction, o_fb_outcome;
  logic              o_mispredict, o_err;
  logic [ADDR_W-1:0] o_fb_pc;
  logic [3:0]        o_count;
  logic [31:0]       o_stat_total, o_stat_miss;

  branch_feedback_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken),
    .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .o_res_ready(o_res_ready),
    .i_flush(i_flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome), .o_mispredict(o_mispredict),
    .o_count(o_count), .o_err(o_err),
    .o_stat_total(o_stat_total), .o_stat_miss(o_stat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              taken;
  } entry_t;

  entry_t            q[$];
  logic [ADDR_W-1:0] m_pc;
  logic              m_pred, m_out, m_err;
  int unsigned       m_tot, m_miss;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pc = '0; m_pred = 1'b0; m_out = 1'b0; m_err = 1'b0;
    m_tot = 0; m_miss = 0;
  endtask

  // One clock: drive inputs, check pre-edge status, update model, check post-edge outputs.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] pc, input logic pt,
                      input logic rv, input logic rt, input logic fl);
    bit full, empty, push, res, mis;
    entry_t e;
    i_pred_valid = pv; i_pred_pc = pc; i_pred_taken = pt;
    i_res_valid = rv; i_res_taken = rt; i_flush = fl;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    check_val("count", 64'(o_count), 64'(q.size()));
    check_val("pred_ready", 64'(o_pred_ready), 64'(!full));
    check_val("res_ready", 64'(o_res_ready), 64'(!empty));
    res  = rv && !empty;
    push = pv && !fl && (!full || res);
    if ((pv && !fl && !push) || (rv && empty)) m_err = 1'b1;
    mis = 1'b0;
    if (res) begin
      e = q.pop_front();
      m_pc = e.pc; m_pred = e.taken; m_out = rt;
      mis = (e.taken != rt);
      m_tot++;
      if (mis) m_miss++;
    end
    if (fl) q.delete();
    else if (push) begin
      e.pc = pc; e.taken = pt;
      q.push_back(e);
    end
    @(posedge clk); #1;
    check_val("fb_valid", 64'(o_fb_valid), 64'(res));
    check_val("mispredict", 64'(o_mispredict), 64'(mis));
    check_val("fb_pc", 64'(o_fb_pc), 64'(m_pc));
    check_val("fb_prediction", 64'(o_fb_prediction), 64'(m_pred));
    check_val("fb_outcome", 64'(o_fb_outcome), 64'(m_out));
    check_val("err", 64'(o_err), 64'(m_err));
`ifdef BFQ_STATS_EN
    check_val("stat_total", 64'(o_stat_total), 64'(m_tot));
    check_val("stat_miss", 64'(o_stat_miss), 64'(m_miss));
`else
    check_val("stat_total", 64'(o_stat_total), 64'd0);
    check_val("stat_miss", 64'(o_stat_miss), 64'd0);
`endif
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset raised between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    check_val("rst_count", 64'(o_count), 64'd0);
    check_val("rst_pred_ready", 64'(o_pred_ready), 64'd1);
    check_val("rst_res_ready", 64'(o_res_ready), 64'd0);
    check_val("rst_fb_valid", 64'(o_fb_valid), 64'd0);
    check_val("rst_err", 64'(o_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst = 1'b1;
    i_pred_valid = 1'b0; i_pred_pc = '0; i_pred_taken = 1'b0;
    i_res_valid = 1'b0; i_res_taken = 1'b0; i_flush = 1'b0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // single mispredicted branch
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("mp_fb_pc", 64'(o_fb_pc), 64'h100);
    check_val("mp_mispredict", 64'(o_mispredict), 64'd1);
    idle();

    // fill, overflow, push+resolve at full, drain across wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i), i[0], 1'b0, 1'b0, 1'b0);
    check_val("full_pred_ready", 64'(o_pred_ready), 64'd0);
    step(1'b1, 32'h2FF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("overflow_err", 64'(o_err), 64'd1);
    step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("full_pr_count", 64'(o_count), 64'd8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("drain_last_pc", 64'(o_fb_pc), 64'h300);
    idle();

    // resolve + flush with three queued
    do_reset();
    step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("flush_fb_pc", 64'(o_fb_pc), 64'h10);
    check_val("flush_count", 64'(o_count), 64'd0);
    check_val("flush_no_err", 64'(o_err), 64'd0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("post_flush_pc", 64'(o_fb_pc), 64'h40);

    // statistics: five resolves, two mispredicts
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 1'b0);
`ifdef BFQ_STATS_EN
    check_val("stats_total5", 64'(o_stat_total), 64'd5);
    check_val("stats_miss2", 64'(o_stat_miss), 64'd2);
`else
    check_val("stats_total0", 64'(o_stat_total), 64'd0);
    check_val("stats_miss0", 64'(o_stat_miss), 64'd0);
`endif

    // resolve when empty, then push+resolve while empty
    idle();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("empty_res_err", 64'(o_err), 64'd1);
    do_reset();
    step(1'b1, 32'h600, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("empty_pr_fb", 64'(o_fb_valid), 64'd0);

    // randomised traffic with occasional mid-run async reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step($urandom_range(0, 99) < 60, $urandom, 1'($urandom),
           $urandom_range(0, 99) < 50, 1'($urandom), $urandom_range(0, 99) < 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
